// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST engine.
// Element index doubles as the reported fail_elem value.
package sram_bist_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;
    localparam logic [2:0] M_NONE = 3'd7;

    function automatic logic [2:0] state_elem(input state_t s);
        case (s)
            ST_M0:   return M0;
            ST_M1:   return M1;
            ST_M2:   return M2;
            ST_M3:   return M3;
            ST_M4:   return M4;
            ST_M5:   return M5;
            default: return M_NONE;
        endcase
    endfunction

    function automatic logic elem_up(input logic [2:0] e);
        return !(e == M3 || e == M4);
    endfunction

    function automatic logic elem_rd(input logic [2:0] e);
        return (e >= M1) && (e <= M5);
    endfunction

    function automatic logic elem_wr(input logic [2:0] e);
        return e <= M4;
    endfunction

    // Background bit: 0 selects D0 (all zeros), 1 selects D1 (all ones).
    function automatic logic elem_rbg(input logic [2:0] e);
        return (e == M2) || (e == M4);
    endfunction

    function automatic logic elem_wbg(input logic [2:0] e);
        return (e == M1) || (e == M3);
    endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// SRAM-side bus of the BIST engine.
// master = BIST, slave = SRAM.
interface sram_march_bist_if #(
    parameter int width = 32,
    parameter int AW    = 3
);
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [width-1:0] mem_wdata;
    logic [width-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/bist_addr_gen.sv
// Up/down address counter for March elements.
// Terminal count follows depth, so non-power-of-2 sizes never overrun.
module bist_addr_gen #(
    parameter  int depth = 8,
    localparam int AW    = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_up,
    input  logic          load_dn,
    input  logic          step,
    output logic          last,
    output logic [AW-1:0] addr
);
    localparam logic [AW-1:0] TOP = AW'(depth - 1);

    logic up;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            up   <= 1'b1;
        end else if (load_up) begin
            addr <= '0;
            up   <= 1'b1;
        end else if (load_dn) begin
            addr <= TOP;
            up   <= 1'b0;
        end else if (step) begin
            addr <= up ? addr + 1'b1 : addr - 1'b1;
        end
    end

    assign last = up ? (addr == TOP) : (addr == '0);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine: drives the SRAM ports, compares read data one
// cycle later and records the first failing address/element.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter  int width = 32,
    parameter  int depth = 8,
    localparam int AW    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW-1:0]    fail_addr,
    output logic [2:0]       fail_elem,
    output logic [ERR_W-1:0] err_count,
    sram_march_bist_if.master mem
);
    state_t           state, nxt;
    logic [2:0]       elem, nx;
    logic             last, ld_up, ld_dn, step;
    logic             we_n;
    logic [width-1:0] wd_n;
    logic [AW-1:0]    addr;

    logic             rd_pend;
    logic [width-1:0] exp_bg;
    logic [AW-1:0]    cmp_addr;
    logic [2:0]       cmp_elem;
    logic             mis;
    logic [ERR_W-1:0] err_n;

    bist_addr_gen #(.depth(depth)) u_addr (
        .clk     (clk),
        .rst     (rst),
        .load_up (ld_up),
        .load_dn (ld_dn),
        .step    (step),
        .last    (last),
        .addr    (addr)
    );

    assign mem.mem_addr = addr;
    assign elem = state_elem(state);

    always_comb begin
        nxt   = state;
        nx    = elem + 3'd1;
        ld_up = 1'b0;
        ld_dn = 1'b0;
        step  = 1'b0;
        we_n  = 1'b0;
        wd_n  = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt   = ST_M0;
                    ld_up = 1'b1;
                    we_n  = 1'b1;
                end
            end
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                // mem_we low inside a read-write element marks its read half
                if (elem_rd(elem) && elem_wr(elem) && !mem.mem_we) begin
                    we_n = 1'b1;
                    wd_n = {width{elem_wbg(elem)}};
                end else if (!last) begin
                    step = 1'b1;
                    we_n = !elem_rd(elem);
                    wd_n = {width{elem_rd(elem) ? elem_rbg(elem)
                                                : elem_wbg(elem)}};
                end else if (state == ST_M5) begin
                    nxt = ST_DRAIN;
                end else begin
                    nxt   = state_t'(state + 4'd1);
                    ld_up = elem_up(nx);
                    ld_dn = !elem_up(nx);
                    wd_n  = {width{elem_rbg(nx)}};
                end
            end
            ST_DRAIN: nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    assign mis   = rd_pend && (mem.mem_rdata != exp_bg);
    assign err_n = (mis && err_count != {ERR_W{1'b1}})
                 ? err_count + 1'b1 : err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            fail_elem     <= '0;
            err_count     <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_wdata <= '0;
            rd_pend       <= 1'b0;
            exp_bg        <= '0;
            cmp_addr      <= '0;
            cmp_elem      <= '0;
        end else begin
            state         <= nxt;
            busy          <= (nxt != ST_IDLE) && (nxt != ST_DONE);
            done          <= (nxt == ST_DONE);
            mem.mem_we    <= we_n;
            mem.mem_wdata <= wd_n;
            // wdata carries the expected background on read cycles
            rd_pend       <= elem_rd(elem) && !mem.mem_we;
            exp_bg        <= mem.mem_wdata;
            cmp_addr      <= addr;
            cmp_elem      <= elem;
            if (state == ST_IDLE && start) begin
                pass      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
                err_count <= '0;
            end else begin
                err_count <= err_n;
                if (mis && err_count == '0) begin
                    fail_addr <= cmp_addr;
                    fail_elem <= cmp_elem;
                end
                if (nxt == ST_DONE) pass <= (err_n == '0);
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: SRAM models with injectable stuck-at cells
// and a March C- reference model built from the element list.
module tb_sram_march_bist;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic go;
    bit   sel6;

    always #5 clk = ~clk;

    sram_march_bist_if #(.width(32), .AW(3)) if8 ();
    sram_march_bist_if #(.width(32), .AW(3)) if6 ();

    logic        start8, busy8, done8, pass8;
    logic [2:0]  fa8, fe8;
    logic [15:0] err8;
    logic        start6, busy6, done6, pass6;
    logic [2:0]  fa6, fe6;
    logic [15:0] err6;

    sram_march_bist #(.width(32), .depth(8)) u8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .busy      (busy8),
        .done      (done8),
        .pass      (pass8),
        .fail_addr (fa8),
        .fail_elem (fe8),
        .err_count (err8),
        .mem       (if8)
    );

    sram_march_bist #(.width(32), .depth(6)) u6 (
        .clk       (clk),
        .rst       (rst),
        .start     (start6),
        .busy      (busy6),
        .done      (done6),
        .pass      (pass6),
        .fail_addr (fa6),
        .fail_elem (fe6),
        .err_count (err6),
        .mem       (if6)
    );

    assign start8 = go && !sel6;
    assign start6 = go && sel6;

    logic        o_busy, o_done, o_pass, o_we;
    logic [2:0]  o_fa, o_fe, o_addr;
    logic [15:0] o_err;
    logic [31:0] o_wd;

    assign o_busy = sel6 ? busy6 : busy8;
    assign o_done = sel6 ? done6 : done8;
    assign o_pass = sel6 ? pass6 : pass8;
    assign o_fa   = sel6 ? fa6 : fa8;
    assign o_fe   = sel6 ? fe6 : fe8;
    assign o_err  = sel6 ? err6 : err8;
    assign o_we   = sel6 ? if6.mem_we : if8.mem_we;
    assign o_addr = sel6 ? if6.mem_addr : if8.mem_addr;
    assign o_wd   = sel6 ? if6.mem_wdata : if8.mem_wdata;

    // Stuck-at cell: bit f_b of word f_a reads back as f_v
    bit f_on;
    int f_a, f_b;
    bit f_v;

    function automatic logic [31:0] flt(input logic [2:0] a,
                                        input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (f_on && int'(a) == f_a) r[f_b] = f_v;
        return r;
    endfunction

    logic [31:0] mem8 [8];
    logic [31:0] mem6 [6];
    int bad6 = 0;

    always @(posedge clk) begin
        if (if8.mem_we) mem8[if8.mem_addr] <= if8.mem_wdata;
        else if8.mem_rdata <= flt(if8.mem_addr, mem8[if8.mem_addr]);
    end

    always @(posedge clk) begin
        if (if6.mem_addr < 3'd6) begin
            if (if6.mem_we) mem6[if6.mem_addr] <= if6.mem_wdata;
            else if6.mem_rdata <= mem6[if6.mem_addr];
        end
        if (busy6 && if6.mem_addr >= 3'd6) bad6 <= bad6 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the March C- element list over a word array
    op_t exp_q[$];
    int  m_err, m_fa, m_fe;

    task automatic model(input int dep);
        logic [31:0] m [8];
        logic [31:0] rv;
        bit up, rb, wb;
        int a;
        exp_q.delete();
        m_err = 0;
        m_fa  = 0;
        m_fe  = 0;
        for (int e = 0; e < 6; e++) begin
            up = !(e == 3 || e == 4);
            rb = (e == 2 || e == 4);
            wb = (e == 1 || e == 3);
            for (int i = 0; i < dep; i++) begin
                a = up ? i : dep - 1 - i;
                if (e > 0) begin
                    exp_q.push_back('{1'b0, 3'(a), {32{rb}}});
                    rv = m[a];
                    if (f_on && a == f_a) rv[f_b] = f_v;
                    if (rv !== {32{rb}}) begin
                        if (m_err == 0) begin
                            m_fa = a;
                            m_fe = e;
                        end
                        m_err++;
                    end
                end
                if (e < 5) begin
                    exp_q.push_back('{1'b1, 3'(a), {32{wb}}});
                    m[a] = {32{wb}};
                end
            end
        end
    endtask

    task automatic run(input int ka, input int kb, input int rst_at,
                       output int blen, output int seq_err,
                       output bit hit_rst);
        int n;
        repeat (2 + $urandom_range(0, 3)) @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk);
        #1;
        go      = 1'b0;
        n       = 0;
        seq_err = 0;
        hit_rst = 1'b0;
        while (o_busy === 1'b1 && n < 2000 && !hit_rst) begin
            if (n < exp_q.size()) begin
                if (o_we !== exp_q[n].we || o_addr !== exp_q[n].addr ||
                    o_wd !== exp_q[n].wd)
                    seq_err++;
            end
            go  = (n == ka || n == kb);
            rst = (n == rst_at);
            n++;
            @(posedge clk);
            #1;
            go = 1'b0;
            if (rst) begin
                rst     = 1'b0;
                hit_rst = 1'b1;
            end
        end
        blen = n;
    endtask

    task automatic check_run(input string tag, input int dep,
                             input int blen, input int seq_err);
        chk({tag, "_len"}, blen, 10 * dep + 1);
        chk({tag, "_seq"}, seq_err, 0);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_pass"}, o_pass, m_err == 0);
        chk({tag, "_err"}, o_err, m_err);
        if (m_err != 0) begin
            chk({tag, "_faddr"}, o_fa, m_fa);
            chk({tag, "_felem"}, o_fe, m_fe);
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, o_done, 0);
    endtask

    initial begin
        int  blen, serr;
        bit  hr;
        int  seen_done, seen_we;

        rst  = 1'b1;
        go   = 1'b0;
        sel6 = 1'b0;
        f_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_err", o_err, 0);
        chk("rst_fa", o_fa, 0);
        chk("rst_fe", o_fe, 0);
        chk("rst_we", o_we, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_wd", o_wd, 0);
        rst = 1'b0;

        model(8);
        run(-1, -1, -1, blen, serr, hr);
        check_run("clean", 8, blen, serr);

        f_on = 1'b1;
        f_a  = 5;
        f_b  = 3;
        f_v  = 1'b1;
        model(8);
        run(-1, -1, -1, blen, serr, hr);
        check_run("sa1_a5b3", 8, blen, serr);

        f_a = 0;
        f_b = 0;
        f_v = 1'b0;
        model(8);
        run(-1, -1, -1, blen, serr, hr);
        check_run("sa0_a0b0", 8, blen, serr);

        for (int k = 0; k < 4; k++) begin
            f_a = $urandom_range(0, 7);
            f_b = $urandom_range(0, 31);
            f_v = 1'($urandom_range(0, 1));
            model(8);
            run(-1, -1, -1, blen, serr, hr);
            check_run("rand_fault", 8, blen, serr);
        end

        f_on = 1'b0;
        model(8);
        run(10, 40, -1, blen, serr, hr);
        check_run("restart_ign", 8, blen, serr);

        run(-1, -1, 25, blen, serr, hr);
        chk("mid_rst_hit", hr, 1);
        chk("mid_rst_len", blen, 26);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_we", o_we, 0);
        chk("mid_rst_addr", o_addr, 0);
        chk("mid_rst_wd", o_wd, 0);
        chk("mid_rst_err", o_err, 0);
        seen_done = 0;
        seen_we   = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (o_done) seen_done++;
            if (o_we) seen_we++;
        end
        chk("mid_rst_nodone", seen_done, 0);
        chk("mid_rst_nowe", seen_we, 0);
        run(-1, -1, -1, blen, serr, hr);
        check_run("after_rst", 8, blen, serr);

        sel6 = 1'b1;
        model(6);
        run(-1, -1, -1, blen, serr, hr);
        check_run("depth6", 6, blen, serr);
        chk("depth6_range", bad6, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test engine that sits directly upstream of the single-port synchronous SRAM. It takes over the SRAM's `we`/`addr`/`data_in` inputs and watches its `data_out`. On `start` it runs a March C- sequence over every address and reports pass/fail, the first failing address and element, and a saturating error count. It is used at bring-up and by the board-level test harness.

## Interface
Parameters:
- `width`, default 32: SRAM data width.
- `depth`, default 8: SRAM word count; must be ≥ 2; need not be a power of two.
- `AW = $clog2(depth)`: derived localparam; address width.

Ports:
- `clk`, in, 1: single clock, shared with the SRAM.
- `rst`, in, 1: reset; synchronous and active-high.
- `start`, in, 1: single-cycle request; honoured only in IDLE.
- `busy`, out, 1: high while the test runs.
- `done`, out, 1: one-cycle pulse at test end.
- `pass`, out, 1: valid from `done` until the next accepted `start`.
- `fail_addr`, out, AW: address of the first mismatch.
- `fail_elem`, out, 3: March element index (1–5) of the first mismatch.
- `err_count`, out, 16: total mismatches; saturates at 16'hFFFF.
- `mem_we`, out, 1: to the SRAM `we`.
- `mem_addr`, out, AW: to the SRAM `addr`.
- `mem_wdata`, out, width: to the SRAM `data_in`.
- `mem_rdata`, in, width: from the SRAM `data_out` (registered; 1-cycle read latency).

## Operation
- Backgrounds: D0 = all zeros, D1 = all ones, each `width` bits wide.
- Elements:
  - M0 ⇑ w0
  - M1 ⇑ (r0, w1)
  - M2 ⇑ (r1, w0)
  - M3 ⇓ (r0, w1)
  - M4 ⇓ (r1, w0)
  - M5 ⇑ r0
- Address order:
  - ⇑ runs 0 → depth-1.
  - ⇓ runs depth-1 → 0.
  - Addresses ≥ depth are never issued.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
- Transitions:
  - IDLE → M0 on `start`.
  - Each Mk → M(k+1) after its last address.
  - M5 → DRAIN → DONE → IDLE.
- Read-write elements alternate per address:
  - Read cycle: `mem_we`=0, address A.
  - Write cycle: `mem_we`=1, same A, new background.
- Comparison:
  - `mem_rdata` is compared to the expected background in the cycle after each read cycle.
  - For M1–M4 that is the write cycle. For M5 it is the next read, or DRAIN for the last one.
- On a mismatch:
  - `err_count` increments.
  - On the first mismatch only: `fail_addr`/`fail_elem` are latched, and the test continues to completion.
- `pass` = (`err_count` == 0) at DONE.
- `start` while `busy` is ignored.
- `start` in IDLE clears `pass`, `fail_addr`, `fail_elem` and `err_count` in the same edge that enters M0.
- All outputs are registered.

## Timing
- Reset value of every output is 0: `busy`, `done`, `pass`, `fail_addr`, `fail_elem`, `err_count`, `mem_we`, `mem_addr`, `mem_wdata`.
- `rst` mid-test forces IDLE at the next edge:
  - `mem_we` is 0 from that edge on.
  - No further writes are issued.
  - `done` is not pulsed.
- Start cycle: `start` is sampled high at edge E. `busy`=1 and the first M0 write are on the ports from E.
- Busy length: `busy` is high for exactly 10·depth + 1 cycles (M0: depth, M1–M4: 2·depth each, M5: depth, DRAIN: 1).
- Completion: `done`=1 and `busy`=0 in the following cycle. `pass` is valid in that same cycle.
- `mem_wdata` is don't-care on read cycles but driven to the expected background.
- No read follows a write to the same address in the same element.

## Structure
- Shared package `sram_bist_pkg` holds:
  - the state enum;
  - element index constants M0–M5;
  - the element direction and background table;
  - `ERR_W` = 16.
- One natural sub-module, `bist_addr_gen`:
  - inputs: load-up, load-down, step;
  - outputs: `last` flag, address;
  - handles the non-power-of-2 terminal count.
- The top level holds the FSM and the compare/capture logic only.

## Test plan
1. Fault-free, width=32, depth=8, wired to the SRAM: `start` → `busy` for 81 cycles, `done` pulse, `pass`=1, `err_count`=0. Verify the exact `mem_we`/`mem_addr` sequence.
2. Stuck-at-1 on bit 3 of address 5 (model wrapper): `fail_elem`=1, `fail_addr`=5, `pass`=0. `err_count`=3 (M1, M3, M5 reads).
3. Stuck-at-0 on bit 0 of address 0: `fail_elem`=2, `fail_addr`=0, `err_count`=2.
4. `start` pulsed again at busy cycles 10 and 40: ignored; the run ends at the same cycle as scenario 1.
5. `rst` asserted at busy cycle 25: next cycle all outputs 0, `mem_we`=0, no `done`. A fresh `start` then gives the scenario 1 result.
6. depth=6: ⇓ elements issue addresses 5,4,3,2,1,0; address 6/7 is never seen; `busy` = 61 cycles; `pass`=1.
